// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Sequences a simple multicycle datapath: FETCH latches the instruction,
//   DECODE selects the ALU operation, EXECUTE issues the register/PC/memory
//   strobes, MEM_WAIT stalls on data memory, HALT parks until resume.
//   All outputs are registered; strobes are single-cycle pulses.
//
// Optional feature: define CTRL_COND_BRANCH_EN to decode JZ (8) / JNZ (9);
//   without it those opcodes behave as NOPs.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   instruction       current memory word, latched in FETCH
//   zero_flag         ALU zero result, sampled in EXECUTE
//   mem_ready         data-memory completion, only looked at in MEM_WAIT
//   resume            leave HALT, only looked at in HALT
//   ir                latched instruction {opcode, rd, rs, imm}
//   rd_addr/rs_addr   register address fields of ir
//   imm               immediate field of ir
//   pc_enable         advance PC (one-cycle pulse)
//   pc_load           load PC from jump target (one-cycle pulse)
//   reg_write_enable  register-file write strobe (one-cycle pulse)
//   alu_op            ALU operation selected in DECODE
//   mem_req, mem_we   data-memory request / write, held through MEM_WAIT
//   halt              high while parked in HALT
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | latch instruction into ir
// DECODE   | select alu_op from opcode
// EXECUTE  | issue strobes, start memory access or halt
// MEM_WAIT | hold mem_req/mem_we until mem_ready
// HALT     | all strobes low, wait for resume

module multicycle_control_unit #(
  parameter int IW   = 16,
  parameter int RAW  = 2,
  parameter int ALUW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IW-1:0]         instruction,
  input  logic                  zero_flag,
  input  logic                  mem_ready,
  input  logic                  resume,
  output logic [IW-1:0]         ir,
  output logic [RAW-1:0]        rd_addr,
  output logic [RAW-1:0]        rs_addr,
  output logic [IW-5-2*RAW:0]   imm,
  output logic                  pc_enable,
  output logic                  pc_load,
  output logic                  reg_write_enable,
  output logic [ALUW-1:0]       alu_op,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  halt
);

  localparam int IMMW = IW - 4 - 2*RAW;

  localparam logic [3:0] OP_LOAD  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
`ifdef CTRL_COND_BRANCH_EN
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
`endif
  localparam logic [3:0] OP_LDM   = 4'hA;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ir_q;
  logic [ALUW-1:0] alu_op_q;
  logic            pc_enable_q, pc_load_q, reg_write_q;
  logic            mem_req_q, mem_we_q, halt_q;

  logic [3:0] opcode;
  assign opcode = ir_q[IW-1 -: 4];

`ifndef CTRL_COND_BRANCH_EN
  logic unused_zero_flag;
  assign unused_zero_flag = zero_flag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      alu_op_q    <= '0;
      pc_enable_q <= 1'b0;
      pc_load_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      // strobes are pulses: low unless a state raises them this cycle
      pc_enable_q <= 1'b0;
      pc_load_q   <= 1'b0;
      reg_write_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          ir_q    <= instruction;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OP_LOAD: alu_op_q <= ALUW'(5);
            OP_ADD:  alu_op_q <= ALUW'(0);
            OP_SUB:  alu_op_q <= ALUW'(1);
            OP_AND:  alu_op_q <= ALUW'(2);
            OP_OR:   alu_op_q <= ALUW'(3);
            default: alu_op_q <= alu_op_q;
          endcase
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          state_q <= S_FETCH;
          case (opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              reg_write_q <= 1'b1;
              pc_enable_q <= 1'b1;
            end
            OP_STORE: begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              state_q   <= S_MEM_WAIT;
            end
            OP_LDM: begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= S_MEM_WAIT;
            end
            OP_JUMP: pc_load_q <= 1'b1;
            OP_HALT: begin
              halt_q  <= 1'b1;
              state_q <= S_HALT;
            end
`ifdef CTRL_COND_BRANCH_EN
            OP_JZ: begin
              pc_load_q   <= zero_flag;
              pc_enable_q <= ~zero_flag;
            end
            OP_JNZ: begin
              pc_load_q   <= ~zero_flag;
              pc_enable_q <= zero_flag;
            end
`endif
            default: pc_enable_q <= 1'b1;
          endcase
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            pc_enable_q <= 1'b1;
            reg_write_q <= (opcode == OP_LDM);
            state_q     <= S_FETCH;
          end
        end
        S_HALT: begin
          if (resume) begin
            halt_q      <= 1'b0;
            pc_enable_q <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          halt_q    <= 1'b0;
          state_q   <= S_FETCH;
        end
      endcase
    end
  end

  assign ir               = ir_q;
  assign rd_addr          = ir_q[IW-5 -: RAW];
  assign rs_addr          = ir_q[IW-5-RAW -: RAW];
  assign imm              = ir_q[IMMW-1:0];
  assign alu_op           = alu_op_q;
  assign pc_enable        = pc_enable_q;
  assign pc_load          = pc_load_q;
  assign reg_write_enable = reg_write_q;
  assign mem_req          = mem_req_q;
  assign mem_we           = mem_we_q;
  assign halt             = halt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int IW   = 16;
  localparam int RAW  = 2;
  localparam int ALUW = 3;
  localparam int IMMW = IW - 4 - 2*RAW;

  localparam int K_ALU   = 0;
  localparam int K_STORE = 1;
  localparam int K_LDM   = 2;
  localparam int K_JUMP  = 3;
  localparam int K_HALT  = 4;
  localparam int K_NOP   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [IW-1:0]   instruction;
  logic            zero_flag, mem_ready, resume;
  logic [IW-1:0]   ir;
  logic [RAW-1:0]  rd_addr, rs_addr;
  logic [IMMW-1:0] imm;
  logic            pc_enable, pc_load, reg_write_enable, mem_req, mem_we, halt;
  logic [ALUW-1:0] alu_op;

  int checks = 0;
  int errors = 0;
  logic [ALUW-1:0] alu_exp;
  logic            in_reset;

  multicycle_control_unit #(.IW(IW), .RAW(RAW), .ALUW(ALUW)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .resume(resume),
    .ir(ir), .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm),
    .pc_enable(pc_enable), .pc_load(pc_load),
    .reg_write_enable(reg_write_enable), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // strobe vector order: {pc_enable, pc_load, reg_write_enable, mem_req, mem_we, halt}
  task automatic check_strobes(input string tag, input logic [5:0] exp);
    check_eq(tag, {26'd0, pc_enable, pc_load, reg_write_enable, mem_req, mem_we, halt},
             {26'd0, exp});
  endtask

  // PC enable and load are mutually exclusive at every sampled cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      check_eq("pc_en_and_load", {31'd0, pc_enable & pc_load}, 32'd0);
  end

  function automatic logic [ALUW-1:0] alu_model(input logic [3:0] op, input logic [ALUW-1:0] prev);
    case (op)
      4'h0:    return ALUW'(5);
      4'h2:    return ALUW'(0);
      4'h3:    return ALUW'(1);
      4'h4:    return ALUW'(2);
      4'h5:    return ALUW'(3);
      default: return prev;
    endcase
  endfunction

  function automatic int kind_of(input logic [3:0] op, input logic zf);
    case (op)
      4'h0, 4'h2, 4'h3, 4'h4, 4'h5: return K_ALU;
      4'h1: return K_STORE;
      4'hA: return K_LDM;
      4'h6: return K_JUMP;
      4'h7: return K_HALT;
`ifdef CTRL_COND_BRANCH_EN
      4'h8: return zf ? K_JUMP : K_NOP;
      4'h9: return zf ? K_NOP : K_JUMP;
`endif
      default: return K_NOP;
    endcase
  endfunction

  // One instruction from its FETCH edge until the next FETCH cycle.
  // delay: cycles mem_req stays visible before completion (>=1).
  // idle: HALT cycles before resume. rst_wait: MEM_WAIT index to reset at (-1 none).
  task automatic exec_instr(input logic [3:0] op, input logic [RAW-1:0] rd,
                            input logic [RAW-1:0] rs, input logic [IMMW-1:0] im,
                            input logic zf, input int delay, input int idle,
                            input int rst_wait);
    logic [IW-1:0] word;
    int kind;
    word = {op, rd, rs, im};
    kind = kind_of(op, zf);
    instruction = word;
    zero_flag = ~zf;
    mem_ready = 1'($urandom);
    resume = 1'($urandom);
    @(posedge clk); #1;
    check_eq("fetch_ir", {16'd0, ir}, {16'd0, word});
    check_strobes("fetch_strobes", 6'b000000);
    instruction = IW'($urandom);
    mem_ready = 1'($urandom);
    resume = 1'($urandom);
    @(posedge clk); #1;
    alu_exp = alu_model(op, alu_exp);
    check_eq("decode_alu_op", {29'd0, alu_op}, {29'd0, alu_exp});
    check_eq("decode_fields", {24'd0, rd_addr, rs_addr, imm}, {24'd0, rd, rs, im});
    check_strobes("decode_strobes", 6'b000000);
    zero_flag = zf;
    mem_ready = 1'($urandom);
    resume = 1'($urandom);
    @(posedge clk); #1;
    zero_flag = 1'($urandom);
    case (kind)
      K_ALU:  check_strobes("exec_alu", 6'b101000);
      K_JUMP: check_strobes("exec_jump", 6'b010000);
      K_NOP:  check_strobes("exec_nop", 6'b100000);
      K_STORE, K_LDM: begin
        check_strobes("exec_mem", {3'b000, 1'b1, kind == K_STORE, 1'b0});
        for (int i = 0; i < delay; i++) begin
          if (i == rst_wait) begin
            #2 rst_n = 1'b0;
            in_reset = 1'b1;
            #1;
            check_strobes("rst_midwait_strobes", 6'b000000);
            check_eq("rst_midwait_ir", {16'd0, ir}, 32'd0);
            check_eq("rst_midwait_alu", {29'd0, alu_op}, 32'd0);
            alu_exp = '0;
            mem_ready = 1'b1;
            repeat (2) begin
              @(posedge clk); #1;
              check_strobes("rst_hold_strobes", 6'b000000);
            end
            @(negedge clk);
            rst_n = 1'b1;
            in_reset = 1'b0;
            mem_ready = 1'b0;
            return;
          end
          mem_ready = (i == delay - 1);
          resume = 1'($urandom);
          @(posedge clk); #1;
          if (i < delay - 1)
            check_strobes("mem_wait_hold", {3'b000, 1'b1, kind == K_STORE, 1'b0});
          else
            check_strobes("mem_done", {1'b1, 1'b0, kind == K_LDM, 3'b000});
        end
      end
      K_HALT: begin
        check_strobes("exec_halt", 6'b000001);
        for (int i = 0; i < idle; i++) begin
          resume = 1'b0;
          mem_ready = 1'($urandom);
          @(posedge clk); #1;
          check_strobes("halt_idle", 6'b000001);
        end
        resume = 1'b1;
        @(posedge clk); #1;
        check_strobes("halt_resume", 6'b100000);
      end
      default: check_eq("bad_kind", 32'(kind), 32'd0);
    endcase
    resume = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    in_reset = 1'b0;
    instruction = '0;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    resume = 1'b0;
    alu_exp = '0;
    #2 rst_n = 1'b0;
    #1;
    check_strobes("reset_strobes", 6'b000000);
    check_eq("reset_ir", {16'd0, ir}, 32'd0);
    check_eq("reset_alu_op", {29'd0, alu_op}, 32'd0);
    mem_ready = 1'b1;
    resume = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_strobes("reset_hold", 6'b000000);
    mem_ready = 1'b0;
    resume = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    exec_instr(4'h0, 2'd1, 2'd0, 8'd5, 1'b0, 1, 0, -1);   // LOAD rd=1 imm=5
    exec_instr(4'h1, 2'd2, 2'd3, 8'h3C, 1'b0, 4, 0, -1);  // STORE, ready after 4
    exec_instr(4'h8, 2'd0, 2'd0, 8'h10, 1'b1, 1, 0, -1);  // JZ, zero=1
    exec_instr(4'h9, 2'd0, 2'd0, 8'h20, 1'b1, 1, 0, -1);  // JNZ, zero=1
    exec_instr(4'h7, 2'd0, 2'd0, 8'h00, 1'b0, 1, 10, -1); // HALT, idle 10
    exec_instr(4'hF, 2'd3, 2'd1, 8'hA5, 1'b0, 1, 0, -1);  // undefined opcode
    exec_instr(4'h6, 2'd1, 2'd2, 8'h44, 1'b0, 1, 0, -1);  // JUMP
    exec_instr(4'hA, 2'd3, 2'd2, 8'h07, 1'b0, 3, 0, -1);  // LDM
    exec_instr(4'h3, 2'd2, 2'd1, 8'h01, 1'b0, 1, 0, -1);  // SUB
    exec_instr(4'h1, 2'd1, 2'd1, 8'h99, 1'b0, 5, 0, 2);   // STORE, reset mid-wait
    exec_instr(4'h2, 2'd1, 2'd2, 8'h11, 1'b0, 1, 0, -1);  // ADD after reset

    for (int n = 0; n < 200; n++) begin
      exec_instr(4'($urandom_range(0, 15)), RAW'($urandom), RAW'($urandom),
                 IMMW'($urandom), 1'($urandom), int'($urandom_range(1, 5)),
                 int'($urandom_range(0, 4)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
